mem_arbiter: RTL and testbench

Two-requester arbiter that lets the core's instruction-fetch port and data port share one single-port synchronous memory. It sits between `riscv` and a unified memory. It grants at most one access per cycle, with data priority by default and a starvation guard for fetch. It routes each read response back to its owner and exposes grant/conflict counters for bench-side performance reporting.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous memory between
// instruction fetch and data, with data priority, a fetch starvation guard and perf counters.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_ce_i,
    input  logic [31:0]      inst_addr_i,
    output logic             inst_gnt_o,
    output logic [31:0]      inst_o,
    output logic             inst_rvalid_o,
    input  logic             data_ce_i,
    input  logic             data_we_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_i,
    output logic             data_gnt_o,
    output logic [31:0]      data_o,
    output logic             data_rvalid_o,
    output logic             mem_ce_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             stall_o,
    output logic [CNT_W-1:0] inst_grants_o,
    output logic [CNT_W-1:0] data_grants_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    logic [SW-1:0]    starve_q, starve_d;
    logic [1:0]       own_q, own_d;
    logic [CNT_W-1:0] igr_q, igr_d;
    logic [CNT_W-1:0] dgr_q, dgr_d;
    logic [CNT_W-1:0] conf_q, conf_d;
    logic             force_inst;
    logic             inst_gnt;
    logic             data_gnt;

    // Grant decision: data wins collisions unless fetch has starved long enough.
    always_comb begin
        force_inst = (starve_q == SW'(STARVE_LIMIT));
        inst_gnt   = 1'b0;
        data_gnt   = 1'b0;
        if (!rst) begin
            data_gnt = data_ce_i & ~(inst_ce_i & force_inst);
            inst_gnt = inst_ce_i & ~data_gnt;
        end
    end

    // Memory port is driven by whichever side holds the grant, zero when idle.
    always_comb begin
        mem_ce_o    = inst_gnt | data_gnt;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (inst_gnt) begin
            mem_addr_o = inst_addr_i;
        end else if (data_gnt) begin
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_i;
        end
    end

    assign inst_gnt_o = inst_gnt;
    assign data_gnt_o = data_gnt;
    assign stall_o    = ~rst & ((inst_ce_i & ~inst_gnt) | (data_ce_i & ~data_gnt));

    always_comb begin
        starve_d = '0;
        if (inst_ce_i && !inst_gnt) begin
            starve_d = force_inst ? starve_q : starve_q + SW'(1);
        end
        own_d = OWN_NONE;
        if (inst_gnt) begin
            own_d = OWN_INST;
        end else if (data_gnt && !data_we_i) begin
            own_d = OWN_DATA;
        end
        igr_d  = igr_q + CNT_W'(inst_gnt);
        dgr_d  = dgr_q + CNT_W'(data_gnt);
        conf_d = conf_q + CNT_W'(inst_ce_i & data_ce_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            own_q    <= OWN_NONE;
            igr_q    <= '0;
            dgr_q    <= '0;
            conf_q   <= '0;
        end else begin
            starve_q <= starve_d;
            own_q    <= own_d;
            igr_q    <= igr_d;
            dgr_q    <= dgr_d;
            conf_q   <= conf_d;
        end
    end

    // Read data is valid one cycle after the grant; the non-owner sees zero.
    assign inst_rvalid_o  = (own_q == OWN_INST);
    assign data_rvalid_o  = (own_q == OWN_DATA);
    assign inst_o         = inst_rvalid_o ? mem_rdata_i : '0;
    assign data_o         = data_rvalid_o ? mem_rdata_i : '0;
    assign inst_grants_o  = igr_q;
    assign data_grants_o  = dgr_q;
    assign conflict_cnt_o = conf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against
// a rule-level model of arbitration, response routing and counters.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ce_i, data_ce_i, data_we_i;
    logic [31:0]   inst_addr_i, data_addr_i, data_i;
    logic          inst_gnt_o, data_gnt_o, inst_rvalid_o, data_rvalid_o;
    logic [31:0]   inst_o, data_o;
    logic          mem_ce_o, mem_we_o, stall_o;
    logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [CW-1:0] inst_grants_o, data_grants_o, conflict_cnt_o;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
        .inst_o(inst_o), .inst_rvalid_o(inst_rvalid_o),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_i(data_i), .data_gnt_o(data_gnt_o), .data_o(data_o),
        .data_rvalid_o(data_rvalid_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
        .inst_grants_o(inst_grants_o), .data_grants_o(data_grants_o),
        .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk = ~clk;

    // Environment memory: single-port, write-then-read across cycles.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_ce_o && !mem_we_o) mem_rdata_i <= ram[mem_addr_o[9:2]];
        if (mem_ce_o && mem_we_o)  ram[mem_addr_o[9:2]] = mem_wdata_o;
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int unsigned m_starve, m_igr, m_dgr, m_conf;
    int          m_own;
    logic [31:0] m_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_starve = 0; m_igr = 0; m_dgr = 0; m_conf = 0; m_own = 0; m_rdata = '0;
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_igrant"}, 32'(inst_gnt_o), 0);
        check({tag, "_dgrant"}, 32'(data_gnt_o), 0);
        check({tag, "_memce"},  32'(mem_ce_o), 0);
        check({tag, "_memwe"},  32'(mem_we_o), 0);
        check({tag, "_stall"},  32'(stall_o), 0);
        check({tag, "_irv"},    32'(inst_rvalid_o), 0);
        check({tag, "_drv"},    32'(data_rvalid_o), 0);
        check({tag, "_inst"},   inst_o, 0);
        check({tag, "_data"},   data_o, 0);
        check({tag, "_icnt"},   inst_grants_o, 0);
        check({tag, "_dcnt"},   data_grants_o, 0);
        check({tag, "_ccnt"},   conflict_cnt_o, 0);
    endtask

    // One clock cycle: drive at negedge, check grants mid-cycle, check responses next negedge.
    task automatic step(input logic ic, input logic [31:0] ia, input logic dc, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        output logic eig, output logic edg, output logic obs_ig);
        logic [31:0] ea;
        inst_ce_i = ic; inst_addr_i = ia;
        data_ce_i = dc; data_we_i = dw; data_addr_i = da; data_i = dd;
        #1;
        edg = dc && !(ic && m_starve == LIMIT);
        eig = ic && !edg;
        ea  = eig ? ia : (edg ? da : 32'h0);
        obs_ig = inst_gnt_o;
        check("inst_gnt", 32'(inst_gnt_o), 32'(eig));
        check("data_gnt", 32'(data_gnt_o), 32'(edg));
        check("stall", 32'(stall_o), 32'((ic && !eig) || (dc && !edg)));
        check("mem_ce", 32'(mem_ce_o), 32'(eig || edg));
        check("mem_we", 32'(mem_we_o), 32'(edg && dw));
        check("mem_addr", mem_addr_o, ea);
        if (edg && dw) check("mem_wdata", mem_wdata_o, dd);
        @(posedge clk);
        m_igr  += eig ? 1 : 0;
        m_dgr  += edg ? 1 : 0;
        m_conf += (ic && dc) ? 1 : 0;
        if (!ic || eig) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        m_own = 0;
        if (eig) begin
            m_own = 1; m_rdata = ref_mem[ia[9:2]];
        end else if (edg && !dw) begin
            m_own = 2; m_rdata = ref_mem[da[9:2]];
        end else if (edg && dw) begin
            ref_mem[da[9:2]] = dd;
        end
        @(negedge clk);
        check("inst_rvalid", 32'(inst_rvalid_o), 32'(m_own == 1));
        check("data_rvalid", 32'(data_rvalid_o), 32'(m_own == 2));
        check("inst_o", inst_o, (m_own == 1) ? m_rdata : 32'h0);
        check("data_o", data_o, (m_own == 2) ? m_rdata : 32'h0);
        check("inst_grants", inst_grants_o, m_igr);
        check("data_grants", data_grants_o, m_dgr);
        check("conflict_cnt", conflict_cnt_o, m_conf);
    endtask

    initial begin
        logic eig, edg, oig;
        logic pi, pd, ic, dc, dw;
        logic [31:0] ia, da, dd;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = (i == 1) ? 32'h0000_0013 : $urandom;
            ref_mem[i] = ram[i];
        end
        rst = 1'b1;
        inst_ce_i = 1'b1; inst_addr_i = 32'h8; data_ce_i = 1'b1;
        data_we_i = 1'b0; data_addr_i = 32'h10; data_i = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs_idle("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        // Both held high for 10 cycles straight out of reset.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, eig, edg, oig);
            check("starve_pattern", 32'(oig), 32'((i % 5) == 4));
            if (i == 0) check("first_conflict", conflict_cnt_o, 1);
        end
        check("starve_igr", inst_grants_o, 2);
        check("starve_dgr", data_grants_o, 8);
        check("starve_conf", conflict_cnt_o, 10);

        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, eig, edg, oig);
        check("lone_fetch_data", inst_o, 32'h0000_0013);

        step(1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, eig, edg, oig);
        step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, eig, edg, oig);

        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, eig, edg, oig);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, eig, edg, oig);
        check("wr_then_rd", data_o, 32'hDEAD_BEEF);

        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h1234_5678, eig, edg, oig);
        step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, eig, edg, oig);
        check("wr_then_fetch", inst_o, 32'h1234_5678);

        // Random traffic; requesters hold until granted.
        pi = 1'b0; pd = 1'b0; ic = 1'b0; dc = 1'b0; dw = 1'b0;
        ia = '0; da = '0; dd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pi) begin
                ic = 1'($urandom_range(0, 3) != 0);
                ia = {22'h0, 8'($urandom), 2'b00};
            end
            if (!pd) begin
                dc = 1'($urandom_range(0, 2) != 0);
                dw = 1'($urandom);
                da = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
                dd = $urandom;
            end
            step(ic, ia, dc, dw, da, dd, eig, edg, oig);
            pi = ic && !eig;
            pd = dc && !edg;
        end

        // Reset lands while a fetch read response is pending.
        inst_ce_i = 1'b1; inst_addr_i = 32'h4; data_ce_i = 1'b0; data_we_i = 1'b0;
        #1;
        check("mid_gnt", 32'(inst_gnt_o), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_gnt_rst", 32'(inst_gnt_o), 0);
        @(posedge clk);
        @(negedge clk);
        check_outputs_idle("mid_rst");
        rst = 1'b0;
        inst_ce_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_after_irv", 32'(inst_rvalid_o), 0);
        check("mid_after_icnt", inst_grants_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
